// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter with valid/ready load and gapless reload
// Define PISO_TX_PARITY_EN to append an even-parity bit after the data bits.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pi,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             done
);

`ifdef PISO_TX_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int            CW   = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit;
  logic             accept;
  logic             data_bit;

  // The reload window is the last bit of the frame, so a held load_valid streams without gaps.
  assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST);
  assign load_ready = (state_q == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;
  assign data_bit   = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];

  assign so_valid = (state_q == SHIFT);
  assign busy     = so_valid;
  assign done     = last_bit;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = SHIFT;
      shreg_d = pi;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
      cnt_d   = cnt_q + CW'(1);
      if (last_bit) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PISO_TX_PARITY_EN
  logic par_q, par_d;

  assign par_d = accept ? ^pi : par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  // Parity occupies the extra final slot, after the data has fully shifted out.
  assign so = (state_q == SHIFT) && (last_bit ? par_q : data_bit);
`else
  assign so = (state_q == SHIFT) && data_bit;
`endif

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - randomized self-checking bench for piso_tx (MSB-first and LSB-first instances)
module tb_piso_tx;
  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif

  typedef struct packed {
    logic m;
    logic l;
    logic last;
  } bit_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] pi;
  logic         load_valid;
  logic         load_ready_m, so_m, so_valid_m, busy_m, done_m;
  logic         load_ready_l, so_l, so_valid_l, busy_l, done_l;

  int           tests = 0;
  int           fails = 0;

  bit_t         q[$];
  logic [W-1:0] sent[$];
  logic [N-1:0] got[$];
  logic [N-1:0] sink;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .pi(pi), .load_valid(load_valid), .load_ready(load_ready_m),
    .so(so_m), .so_valid(so_valid_m), .busy(busy_m), .done(done_m)
  );

  piso_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .pi(pi), .load_valid(load_valid), .load_ready(load_ready_l),
    .so(so_l), .so_valid(so_valid_l), .busy(busy_l), .done(done_l)
  );

  function automatic logic [N-1:0] frame_vec(input logic [W-1:0] w);
`ifdef PISO_TX_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  function automatic logic [9:0] obs();
    return {so_m, so_valid_m, busy_m, done_m, load_ready_m, so_l, so_valid_l, busy_l, done_l, load_ready_l};
  endfunction

  // Expected outputs follow directly from the queue of bits still to be presented.
  function automatic logic [9:0] expv();
    if (q.size() == 0) return 10'b00001_00001;
    return {q[0].m, 2'b11, q[0].last, q[0].last, q[0].l, 2'b11, q[0].last, q[0].last};
  endfunction

  task automatic tick(input logic lv, input logic [W-1:0] p, output logic acc);
    bit_t b;
    load_valid = lv;
    pi         = p;
    if (so_valid_m === 1'b1) begin
      sink = {sink[N-2:0], so_m};
      if (done_m === 1'b1) got.push_back(sink);
    end
    acc = lv && (q.size() <= 1);
    @(posedge clk);
    if (q.size() > 0) void'(q.pop_front());
    if (acc) begin
      sent.push_back(p);
      for (int i = 0; i < N; i++) begin
        if (i < W) begin
          b.m = p[W-1-i];
          b.l = p[i];
        end else begin
          b.m = ^p;
          b.l = ^p;
        end
        b.last = (i == N - 1);
        q.push_back(b);
      end
    end
    #1;
  endtask

  task automatic clear_model();
    q.delete();
    sent.delete();
    got.delete();
    sink = '0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    load_valid = 1'b1;
    pi         = 4'($urandom);
    #3;
    tests++;
    if (obs() !== 10'b00001_00001) begin
      fails++;
      $display("FAIL reset_async got %b exp %b", obs(), 10'b00001_00001);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (obs() !== 10'b00001_00001) begin
      fails++;
      $display("FAIL reset_hold got %b exp %b", obs(), 10'b00001_00001);
    end
    load_valid = 1'b0;
    rst_n      = 1'b1;
    clear_model();
  endtask

  task automatic test_single();
    logic         acc;
    logic [N-1:0] stream;
    stream = '0;
    tick(1'b1, 4'b1011, acc);
    for (int c = 0; c <= N; c++) begin
      if (c > 0) tick(1'b0, 4'($urandom), acc);
      tests++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL single c%0d got %b exp %b", c, obs(), expv());
      end
      if (c < N) stream = {stream[N-2:0], so_m};
    end
    tests++;
    if (stream !== frame_vec(4'b1011)) begin
      fails++;
      $display("FAIL single_stream got %b exp %b", stream, frame_vec(4'b1011));
    end
  endtask

  task automatic test_back_to_back();
    logic           acc;
    logic [W-1:0]   words [2];
    logic [2*N-1:0] stream;
    int             idx;
    words[0] = 4'b1011;
    words[1] = 4'b0110;
    idx      = 0;
    stream   = '0;
    for (int c = 0; c < 2 * N + 2; c++) begin
      tick(idx < 2, (idx < 2) ? words[idx] : 4'b0000, acc);
      if (acc) idx++;
      tests++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL b2b c%0d got %b exp %b", c, obs(), expv());
      end
      if (c < 2 * N) stream = {stream[2*N-2:0], so_m};
    end
    tests++;
    if (stream !== {frame_vec(words[0]), frame_vec(words[1])}) begin
      fails++;
      $display("FAIL b2b_stream got %b exp %b", stream, {frame_vec(words[0]), frame_vec(words[1])});
    end
  endtask

  task automatic test_busy_reject();
    logic         acc;
    logic [N-1:0] stream;
    stream = '0;
    for (int c = 0; c < N + 2; c++) begin
      if (c == 0)      tick(1'b1, 4'b1001, acc);
      else if (c == 2) tick(1'b1, 4'b1111, acc);
      else             tick(1'b0, 4'b1111, acc);
      tests++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL busy_reject c%0d got %b exp %b", c, obs(), expv());
      end
      if (c < N) stream = {stream[N-2:0], so_m};
    end
    tests++;
    if (stream !== frame_vec(4'b1001)) begin
      fails++;
      $display("FAIL busy_reject_stream got %b exp %b", stream, frame_vec(4'b1001));
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    tick(1'b1, 4'b1101, acc);
    tick(1'b0, 4'b0000, acc);
    tick(1'b0, 4'b0000, acc);
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs() !== 10'b00001_00001) begin
      fails++;
      $display("FAIL reset_mid_now got %b exp %b", obs(), 10'b00001_00001);
    end
    load_valid = 1'b1;
    pi         = 4'b1111;
    @(posedge clk);
    #1;
    tests++;
    if (obs() !== 10'b00001_00001) begin
      fails++;
      $display("FAIL reset_mid_load got %b exp %b", obs(), 10'b00001_00001);
    end
    load_valid = 1'b0;
    rst_n      = 1'b1;
    clear_model();
    for (int c = 0; c < N + 2; c++) begin
      tick(1'b0, 4'($urandom), acc);
      tests++;
      if (obs() !== 10'b00001_00001) begin
        fails++;
        $display("FAIL reset_mid_residual c%0d got %b exp %b", c, obs(), 10'b00001_00001);
      end
    end
  endtask

  task automatic test_random_loopback();
    logic         acc;
    logic         pend;
    logic [W-1:0] w;
    clear_model();
    pend = 1'b0;
    w    = '0;
    for (int c = 0; c < 400 + N + 2; c++) begin
      if (c < 400 && !pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        w    = 4'($urandom);
      end
      tick(pend, pend ? w : 4'($urandom), acc);
      if (acc) pend = 1'b0;
      tests++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL random c%0d got %b exp %b", c, obs(), expv());
      end
    end
    tests++;
    if (got.size() != sent.size() || sent.size() == 0) begin
      fails++;
      $display("FAIL loopback_count got %0d exp %0d", got.size(), sent.size());
    end
    for (int i = 0; i < got.size() && i < sent.size(); i++) begin
      tests++;
      if (got[i] !== frame_vec(sent[i])) begin
        fails++;
        $display("FAIL loopback_word%0d got %b exp %b", i, got[i], frame_vec(sent[i]));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    pi         = '0;
    sink       = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid();
    test_random_loopback();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
